// File: rtl/fuzzy_centroid_defuzz.sv
// fuzzy_centroid_defuzz: bit-serial centroid of a fuzzy set.
// Scans set bits, then restoring-divides index sum by popcount.
module fuzzy_centroid_defuzz #(
  parameter int LongBits_limit = 10,
  parameter int IDX_W = $clog2(LongBits_limit),
  parameter int SUM_W = $clog2(LongBits_limit*(LongBits_limit-1)/2+1),
  parameter int CNT_W = $clog2(LongBits_limit+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LongBits_limit-1:0] in_set,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_value,
  output logic                      out_empty
);

  localparam int RW = CNT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(LongBits_limit - 1);
  localparam logic [IDX_W-1:0] DIV_TOP =
    IDX_W'(IDX_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DIV,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LongBits_limit-1:0] shift_q;
  logic [SUM_W-1:0]          sum_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CNT_W-1:0]          rem_q;
  logic [IDX_W-1:0]          dvd_q;
  logic [IDX_W-1:0]          quo_q;

  logic                      scan_bit;
  logic                      scan_last;
  logic [SUM_W-1:0]          sum_nx;
  logic [CNT_W-1:0]          cnt_nx;
  logic [CNT_W-1:0]          rem_init;
  logic [IDX_W-1:0]          dvd_init;
  logic [RW-1:0]             rem_sh;
  logic                      rem_ge;
  logic [CNT_W-1:0]          rem_sub;
  logic [CNT_W-1:0]          rem_nx;
  logic [IDX_W-1:0]          quo_nx;
  logic                      div_last;

  assign in_ready = (state_q == IDLE);

  // Scan accumulate and one restoring-divide step.
  // Dividend high bits seed the remainder: quotient < 2^IDX_W
  // guarantees sum >> IDX_W is already below the divisor.
  always_comb begin
    scan_bit  = shift_q[0];
    scan_last = (idx_q == LAST_IDX);
    sum_nx    = sum_q + (scan_bit ? SUM_W'(idx_q) : '0);
    cnt_nx    = cnt_q + CNT_W'(scan_bit);
    rem_init  = CNT_W'(sum_nx >> IDX_W);
    dvd_init  = sum_nx[IDX_W-1:0];
    rem_sh    = {rem_q, dvd_q[IDX_W-1]};
    rem_ge    = (rem_sh >= RW'(cnt_q));
    rem_sub   = rem_sh[CNT_W-1:0] - cnt_q;
    rem_nx    = rem_ge ? rem_sub : rem_sh[CNT_W-1:0];
    quo_nx    = (quo_q << 1) | IDX_W'(rem_ge);
    div_last  = (idx_q == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = SCAN;
      end
      SCAN: begin
        if (scan_last) begin
          state_d = (cnt_nx != '0) ? DIV : DONE;
        end
      end
      DIV: begin
        if (div_last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      out_value <= '0;
      out_empty <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q <= in_set;
            sum_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          shift_q <= shift_q >> 1;
          sum_q   <= sum_nx;
          cnt_q   <= cnt_nx;
          idx_q   <= idx_q + IDX_W'(1);
          if (scan_last) begin
            idx_q <= DIV_TOP;
            rem_q <= rem_init;
            dvd_q <= dvd_init;
            quo_q <= '0;
            if (cnt_nx == '0) begin
              out_value <= '0;
              out_empty <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end
        DIV: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_q << 1;
          quo_q <= quo_nx;
          idx_q <= idx_q - IDX_W'(1);
          if (div_last) begin
            out_value <= quo_nx;
            out_empty <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzzy_centroid_defuzz.sv
// tb_fuzzy_centroid_defuzz: directed + random checks
// against a transaction-level centroid model.
module tb_fuzzy_centroid_defuzz;

  localparam int N  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  in_set = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_empty;
  logic [IW-1:0] out_value;

  int n_vec = 0;
  int n_err = 0;

  fuzzy_centroid_defuzz #(.LongBits_limit(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_set(in_set),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_empty(out_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void centroid(input logic [N-1:0] s,
                                   output int v,
                                   output bit e,
                                   output int lat);
    int sum;
    int cnt;
    sum = 0;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (s[i]) begin
        sum += i;
        cnt++;
      end
    end
    e   = (cnt == 0);
    v   = e ? 0 : sum / cnt;
    lat = e ? N : N + IW;
  endfunction

  // Transaction model: result appears lat edges after accept.
  logic m_ready = 1'b1;
  logic m_valid = 1'b0;
  int   m_value = 0;
  logic m_empty = 1'b0;
  int   m_pv = 0;
  logic m_pe = 1'b0;
  int   m_timer = 0;

  always @(posedge clk or negedge rst_n) begin
    int v;
    int l;
    bit e;
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_value <= 0;
      m_empty <= 1'b0;
      m_timer <= 0;
    end else if (m_ready && in_valid) begin
      centroid(in_set, v, e, l);
      m_pv    <= v;
      m_pe    <= e;
      m_timer <= l;
      m_ready <= 1'b0;
    end else if (m_timer != 0) begin
      m_timer <= m_timer - 1;
      if (m_timer == 1) begin
        m_valid <= 1'b1;
        m_value <= m_pv;
        m_empty <= m_pe;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_value", 32'(out_value), m_value);
    chk("out_empty", 32'(out_empty), 32'(m_empty));
  end

  task automatic wait_valid(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        k = i;
        return;
      end
    end
  endtask

  task automatic send(input logic [N-1:0] s,
                      input int ev,
                      input int ee,
                      input int el);
    int k;
    chk("idle_before", 32'(in_ready), 1);
    in_set    = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(k);
    chk("latency", k, el);
    chk("value", 32'(out_value), ev);
    chk("empty", 32'(out_empty), ee);
    @(posedge clk);
    #1 chk("valid_pulse", 32'(out_valid), 0);
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_value", 32'(out_value), 0);
    chk("rst_empty", 32'(out_empty), 0);
    rst_n = 1'b1;

    send(10'h001, 0, 0, 14);
    send(10'h01C, 3, 0, 14);
    send(10'h201, 4, 0, 14);
    send(10'h3FF, 4, 0, 14);
    send(10'h200, 9, 0, 14);
    send(10'h000, 0, 1, 10);

    in_set    = 10'h01C;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(k);
    chk("bp_latency", k, 14);
    in_set   = 10'h3FF;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_value", 32'(out_value), 3);
      chk("bp_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_ready", 32'(in_ready), 1);
    chk("hs_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(k);
    chk("bp2_latency", k, 14);
    chk("bp2_value", 32'(out_value), 4);
    @(posedge clk);
    #1;

    in_set   = 10'h01C;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_value", 32'(out_value), 0);
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_empty", 32'(out_empty), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1 chk("no_stale", 32'(out_valid), 0);
    end
    send(10'h200, 9, 0, 14);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_set    = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
